// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone command master.
// State encoding plus default bus geometry and abort limit.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle master for the MAC register space.
// Optional bus abort counter enabled by WB_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_int_i,
  output logic              int_pulse
);

  state_t state;
  state_t state_nxt;
  logic   tmo;
  logic   int_q;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Abort on the last allowed BUS cycle unless ack arrives in it.
  assign tmo = (state == BUS) && !wb_ack_i && (cnt == CNT_LAST);

  // Count BUS cycles spent waiting; restarts every time BUS is entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (state != BUS) begin
      cnt <= '0;
    end else if (!wb_ack_i) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: one outstanding transaction at a time.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = BUS;
      BUS:     if (wb_ack_i || tmo) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and bus strobes decoded from the state.
  always_comb begin
    cmd_ready = (state == IDLE) && !wb_rst_i;
    wb_cyc_o  = (state == BUS);
    wb_stb_o  = (state == BUS);
    rsp_valid = (state == RESP);
  end

  // Latch the command onto the bus; capture the result on ack or abort.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == IDLE && cmd_valid) begin
      wb_adr_o <= cmd_adr;
      wb_dat_o <= cmd_wdata;
      wb_we_o  <= cmd_we;
    end else if (state == BUS && (wb_ack_i || tmo)) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      rsp_rdata <= (wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
      rsp_err   <= tmo;
    end
  end

  // Rising-edge detector on the slave interrupt level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      int_q     <= 1'b0;
      int_pulse <= 1'b0;
    end else begin
      int_q     <= wb_int_i;
      int_pulse <= wb_int_i & ~int_q;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed cases then random traffic
// checked each cycle against a transaction-level model.
module tb_wb_cmd_master;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 8;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_stb;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack;
  logic          wb_int;
  logic          int_pulse;

  int errors = 0;
  int checks = 0;

  wb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_adr_o  (wb_adr),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack),
    .wb_int_i  (wb_int),
    .int_pulse (int_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: what is on the bus, what is waiting
  // to be returned, and the last level seen on the interrupt.
  bit            m_on_bus;
  bit            m_has_rsp;
  int            m_waited;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata;
  bit            m_we;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  bit            m_int_last;
  bit            m_pulse;
  bit            cmp_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_on_bus   = 0;
      m_has_rsp  = 0;
      m_waited   = 0;
      m_adr      = '0;
      m_wdata    = '0;
      m_we       = 0;
      m_rdata    = '0;
      m_err      = 0;
      m_int_last = 0;
      m_pulse    = 0;
    end else begin
      m_pulse    = wb_int && !m_int_last;
      m_int_last = wb_int;
      if (m_on_bus) begin
        if (wb_ack) begin
          m_on_bus  = 0;
          m_has_rsp = 1;
          m_rdata   = m_we ? '0 : wb_dat_i;
          m_err     = 0;
        end else if (TMO_ON && m_waited + 1 == TMO) begin
          m_on_bus  = 0;
          m_has_rsp = 1;
          m_rdata   = '0;
          m_err     = 1;
        end else begin
          m_waited++;
        end
      end else if (m_has_rsp) begin
        if (rsp_ready) m_has_rsp = 0;
      end else if (cmd_valid) begin
        m_on_bus = 1;
        m_waited = 0;
        m_adr    = cmd_adr;
        m_wdata  = cmd_wdata;
        m_we     = cmd_we;
      end
    end
    cmp_on = 1'b1;
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!rst && !m_on_bus && !m_has_rsp));
      chk("wb_cyc", 32'(wb_cyc), 32'(m_on_bus));
      chk("wb_stb", 32'(wb_stb), 32'(m_on_bus));
      chk("wb_adr", 32'(wb_adr), m_on_bus ? 32'(m_adr) : 32'd0);
      chk("wb_dat_o", wb_dat_o, m_on_bus ? m_wdata : 32'd0);
      chk("wb_we", 32'(wb_we), 32'(m_on_bus && m_we));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_has_rsp));
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("int_pulse", 32'(int_pulse), 32'(m_pulse));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int n;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    wb_dat_i  = '0;
    wb_ack    = 1'b0;
    wb_int    = 1'b0;

    step();
    @(negedge clk);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset cyc", 32'(wb_cyc), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

    // Write with ack in the first BUS cycle (ack in IDLE is ignored).
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 8'h10;
    cmd_wdata = 32'hDEADBEEF;
    wb_ack    = 1'b1;
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("wr cyc", 32'(wb_cyc), 32'd1);
    chk("wr we", 32'(wb_we), 32'd1);
    chk("wr adr", 32'(wb_adr), 32'h10);
    chk("wr dat", wb_dat_o, 32'hDEADBEEF);
    step();
    wb_ack = 1'b0;
    @(negedge clk);
    chk("wr rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr cyc drop", 32'(wb_cyc), 32'd0);
    chk("wr rdata", rsp_rdata, 32'd0);
    chk("wr err", 32'(rsp_err), 32'd0);

    // Response back-pressure with a read pending.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 8'h24;
    cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post hs cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;

    // Read with three wait states.
    n = 0;
    for (int i = 0; i < 4; i++) begin
      wb_ack   = (i == 3);
      wb_dat_i = (i == 3) ? 32'h12345678 : 32'hA5A5A5A5;
      @(negedge clk);
      if (wb_cyc) n++;
      step();
    end
    wb_ack = 1'b0;
    @(negedge clk);
    chk("rd cyc cycles", 32'(n), 32'd4);
    chk("rd rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd rdata", rsp_rdata, 32'h12345678);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset two cycles into BUS; a later ack must be ignored.
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 8'h33;
    cmd_wdata = 32'h0BADF00D;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    wb_ack = 1'b1;
    @(negedge clk);
    chk("rst cyc", 32'(wb_cyc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst no rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    wb_ack = 1'b0;

    // Interrupt level held high for 10 cycles.
    wb_int = 1'b1;
    step();
    @(negedge clk);
    chk("int first", 32'(int_pulse), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (int_pulse) n++;
    end
    chk("int extra pulses", 32'(n), 32'd0);
    wb_int = 1'b0;
    step();

`ifdef WB_MASTER_TIMEOUT_EN
    // No ack: abort after TMO cycles.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 8'h44;
    step();
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < TMO + 4; i++) begin
      @(negedge clk);
      if (wb_cyc) n++;
      step();
    end
    chk("tmo cyc cycles", 32'(n), 32'(TMO));
    chk("tmo err", 32'(rsp_err), 32'd1);
    chk("tmo rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    // Ack in the last allowed cycle wins.
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      wb_ack   = (i == TMO - 1);
      wb_dat_i = 32'hCAFE0001;
      step();
    end
    wb_ack = 1'b0;
    @(negedge clk);
    chk("late ack valid", 32'(rsp_valid), 32'd1);
    chk("late ack err", 32'(rsp_err), 32'd0);
    chk("late ack rdata", rsp_rdata, 32'hCAFE0001);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_we    = $urandom_range(0, 1) == 1;
      cmd_adr   = AW'($urandom);
      cmd_wdata = $urandom;
      rsp_ready = $urandom_range(0, 1) == 1;
      wb_ack    = $urandom_range(0, 9) < 3;
      wb_dat_i  = $urandom;
      if ($urandom_range(0, 7) == 0) wb_int = ~wb_int;
      step();
    end
    rst = 1'b0;
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-cycle bus master for the 10G MAC register space. Accepts register read/write commands on a valid/ready request channel, runs one Wishbone cycle against the MAC's register slave, and returns read data and status on a valid/ready response channel. It sits between host/test-sequencer logic and the MAC's register port, and also edge-detects the MAC interrupt line.

## Interface
- ADDR_W, 8, Wishbone address width
- DATA_W, 32, Wishbone data width
- TIMEOUT_CYCLES, 64, max cycles cyc/stb held without ack before abort (used only with timeout compiled in)

- wb_clk_i  in  1  bus clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_adr  in  ADDR_W  register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  1=cycle aborted by timeout
- wb_adr_o  out  ADDR_W  address to slave
- wb_dat_o  out  DATA_W  write data to slave
- wb_we_o  out  1  write enable to slave
- wb_cyc_o  out  1  cycle valid
- wb_stb_o  out  1  strobe
- wb_dat_i  in  DATA_W  read data from slave
- wb_ack_i  in  1  slave acknowledge
- wb_int_i  in  1  slave interrupt level
- int_pulse  out  1  one-cycle pulse on wb_int_i rising edge

## Operation
- FSM states IDLE, BUS, RESP; reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid: latch adr/we/wdata onto wb_adr_o/wb_we_o/wb_dat_o, assert wb_cyc_o=wb_stb_o=1, go BUS.
- BUS: cmd_ready=0; cyc/stb held, adr/we/dat stable. On wb_ack_i: drop cyc/stb, capture rsp_rdata = we ? 0 : wb_dat_i, rsp_err=0, rsp_valid=1, go RESP.
- RESP: hold rsp_* until rsp_ready; on rsp_valid&rsp_ready clear rsp_valid, go IDLE. No new command accepted while in RESP (one outstanding transaction).
- wb_ack_i outside BUS ignored.
- int_pulse = wb_int_i & ~int_q, int_q registered wb_int_i; independent of FSM.
- Reset values: cmd_ready=0 during reset cycle then 1 in IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, int_pulse=0, int_q=0.
- Reset mid-cycle: cyc/stb deasserted at the reset edge, pending command and response discarded, no response emitted.

## Timing
- Command accepted at edge N -> cyc/stb high from cycle N+1.
- Ack sampled at edge M (cycle in BUS) -> cyc/stb low and rsp_valid high from cycle M+1.
- Minimum command-to-response: 2 cycles (ack in first BUS cycle); minimum back-to-back throughput: one transaction per 3 cycles with rsp_ready tied high.
- int_pulse lags wb_int_i rise by one cycle, width exactly 1 cycle.

## Configuration
- WB_MASTER_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES+1) cleared on entering BUS, incremented each BUS cycle without ack; when it reaches TIMEOUT_CYCLES with no ack, drop cyc/stb, rsp_err=1, rsp_rdata=0, go RESP. Ack in the same cycle the count reaches the limit wins (normal response).
- Not defined: no counter; BUS waits indefinitely for ack; rsp_err constant 0.

## Structure
- Package wb_master_pkg: state enum (IDLE, BUS, RESP), default ADDR_W/DATA_W/TIMEOUT_CYCLES constants.
- Single module; no sub-module (edge detector and counter are too small to split).

## Test plan
- Write 0xDEADBEEF to 0x10, slave acks on first cycle -> wb_we_o=1, wb_dat_o=0xDEADBEEF for 1 cycle, rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x24, slave acks after 3 wait cycles returning 0x12345678 -> cyc/stb high 4 cycles, rsp_rdata=0x12345678.
- rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout, next command accepted only after handshake.
- Timeout build, TIMEOUT_CYCLES=8, no ack -> cyc/stb drop after 8 cycles, rsp_err=1, rsp_rdata=0; ack arriving on 8th cycle -> rsp_err=0.
- wb_rst_i asserted 2 cycles into BUS -> cyc/stb low next cycle, rsp_valid never asserted, later ack ignored.
- wb_int_i rises and stays high 10 cycles -> exactly one int_pulse, one cycle after rise.
